// File: rtl/drop_controller.sv
// ============================================================================
// Module   : drop_controller
// Purpose  : Computes the limit time t_lim = sqrt(height) in 4.4 fixed point
//            with a bit-serial restoring square root. It then classifies the
//            measured fall time t_act as COLD, HOT or DROP.
// Options  : SQRT_ROUND_EN -- when defined, t_lim is rounded to the nearest
//            value (saturating at 8'hFF). Otherwise t_lim is the floor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module drop_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] height,
  input  logic [7:0] t_act,
  input  logic       drop_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] t_lim,
  output logic [1:0] status,
  output logic       drop_activated
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_CMP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] ST_COLD = 2'd1;
  localparam logic [1:0] ST_HOT  = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  state_t      state_q, state_d;
  logic [15:0] rad_q, rad_d;
  logic [9:0]  rem_q, rem_d;
  logic [7:0]  root_q, root_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  t_act_q, t_act_d;
  logic        drop_en_q, drop_en_d;
  logic [7:0]  res_lim_q, res_lim_d;
  logic [1:0]  res_st_q, res_st_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  t_lim_q, t_lim_d;
  logic [1:0]  status_q, status_d;
  logic        drop_q, drop_d;

  logic [9:0]  w_rem_sh;
  logic [9:0]  w_trial;
  logic [7:0]  w_lim;

  // One square-root step plus the final limit value, derived from the current state.
  always_comb begin
    w_rem_sh = {rem_q[7:0], rad_q[15:14]};
    w_trial  = {root_q, 2'b01};
`ifdef SQRT_ROUND_EN
    // A remainder larger than the root means the true root lies above root + 0.5.
    if ((rem_q > {2'b00, root_q}) && (root_q != 8'hFF)) begin
      w_lim = root_q + 8'd1;
    end else begin
      w_lim = root_q;
    end
`else
    w_lim = root_q;
`endif
  end

  // Next-state logic. busy and done are derived from the state one cycle
  // late, so busy also covers the done cycle and a start seen then is dropped.
  always_comb begin
    state_d   = state_q;
    rad_d     = rad_q;
    rem_d     = rem_q;
    root_d    = root_q;
    cnt_d     = cnt_q;
    t_act_d   = t_act_q;
    drop_en_d = drop_en_q;
    res_lim_d = res_lim_q;
    res_st_d  = res_st_q;
    t_lim_d   = t_lim_q;
    status_d  = status_q;
    drop_d    = drop_q;
    busy_d    = (state_q != S_IDLE);
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          t_act_d   = t_act;
          drop_en_d = drop_en;
          rad_d     = {height, 8'h00};
          rem_d     = 10'd0;
          root_d    = 8'd0;
          cnt_d     = 3'd0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (w_rem_sh >= w_trial) begin
          rem_d  = w_rem_sh - w_trial;
          root_d = {root_q[6:0], 1'b1};
        end else begin
          rem_d  = w_rem_sh;
          root_d = {root_q[6:0], 1'b0};
        end
        rad_d = {rad_q[13:0], 2'b00};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        res_lim_d = w_lim;
        if (t_act_q < w_lim) begin
          res_st_d = ST_COLD;
        end else if (drop_en_q) begin
          res_st_d = ST_DROP;
        end else begin
          res_st_d = ST_HOT;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        t_lim_d  = res_lim_q;
        status_d = res_st_q;
        drop_d   = (res_st_q == ST_DROP);
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rad_q     <= 16'd0;
      rem_q     <= 10'd0;
      root_q    <= 8'd0;
      cnt_q     <= 3'd0;
      t_act_q   <= 8'd0;
      drop_en_q <= 1'b0;
      res_lim_q <= 8'd0;
      res_st_q  <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      t_lim_q   <= 8'd0;
      status_q  <= 2'd0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rad_q     <= rad_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      cnt_q     <= cnt_d;
      t_act_q   <= t_act_d;
      drop_en_q <= drop_en_d;
      res_lim_q <= res_lim_d;
      res_st_q  <= res_st_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      t_lim_q   <= t_lim_d;
      status_q  <= status_d;
      drop_q    <= drop_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign t_lim          = t_lim_q;
  assign status         = status_q;
  assign drop_activated = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_drop_controller.sv
// ============================================================================
// Module   : tb_drop_controller
// Purpose  : Self-checking bench for drop_controller. It contains a
//            transaction-level reference model and compares the DUT against
//            it on every cycle. Directed and random stimulus are applied.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_drop_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] height;
  logic [7:0] t_act;
  logic       drop_en;
  logic       busy;
  logic       done;
  logic [7:0] t_lim;
  logic [1:0] status;
  logic       drop_activated;

  int n_tests = 0;
  int n_fail  = 0;

  drop_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .height         (height),
    .t_act          (t_act),
    .drop_en        (drop_en),
    .busy           (busy),
    .done           (done),
    .t_lim          (t_lim),
    .status         (status),
    .drop_activated (drop_activated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // sqrt(height) in 4.4 is sqrt(height*256); search for the integer root.
  function automatic int lim_model(input int h);
    int v;
    int r;
    int rem;
    v = h * 256;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    rem = v - r * r;
`ifdef SQRT_ROUND_EN
    if (rem > r && r < 255) r++;
`endif
    return r;
  endfunction

  function automatic int status_model(input int t, input int lim, input int de);
    if (t < lim) return 1;
    return (de != 0) ? 3 : 2;
  endfunction

  // Reference model: age counts edges since the accepted start (-1 when idle).
  int       m_age = -1;
  int       m_h, m_t, m_de;
  int       e_busy = 0, e_done = 0, e_tlim = 0, e_status = 0, e_drop = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_age = -1;
      e_tlim = 0; e_status = 0; e_drop = 0;
    end else if (m_age == -1) begin
      if (start) begin
        m_age = 0;
        m_h = height; m_t = t_act; m_de = drop_en;
      end
    end else if (m_age == 10) begin
      m_age = -1;
    end else begin
      m_age = m_age + 1;
      if (m_age == 10) begin
        e_tlim   = lim_model(m_h);
        e_status = status_model(m_t, e_tlim, m_de);
        e_drop   = (e_status == 3) ? 1 : 0;
      end
    end
    e_busy = (m_age >= 1) ? 1 : 0;
    e_done = (m_age == 10) ? 1 : 0;
  end

  // Compare the DUT to the model in the middle of every cycle.
  always @(negedge clk) begin
    chk("cyc_busy",   int'(busy),           e_busy);
    chk("cyc_done",   int'(done),           e_done);
    chk("cyc_t_lim",  int'(t_lim),          e_tlim);
    chk("cyc_status", int'(status),         e_status);
    chk("cyc_drop",   int'(drop_activated), e_drop);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_directed(input string nm, input logic [7:0] h, input logic [7:0] t,
                              input logic de, input int exp_lim, input int exp_st);
    int n;
    n = 99;
    height = h; t_act = t; drop_en = de; start = 1'b1;
    tick();
    start = 1'b0;
    height = 8'($urandom); t_act = 8'($urandom); drop_en = 1'($urandom);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
    chk({nm, "_latency"}, n, 10);
    chk({nm, "_t_lim"},   int'(t_lim), exp_lim);
    chk({nm, "_status"},  int'(status), exp_st);
    chk({nm, "_drop"},    int'(drop_activated), (exp_st == 3) ? 1 : 0);
    repeat (3) tick();
  endtask

  int first_done;
  int n_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; height = 8'd0; t_act = 8'd0; drop_en = 1'b0;
    repeat (2) tick();
    chk("rst_busy",   int'(busy), 0);
    chk("rst_done",   int'(done), 0);
    chk("rst_t_lim",  int'(t_lim), 0);
    chk("rst_status", int'(status), 0);
    chk("rst_drop",   int'(drop_activated), 0);
    rst_n = 1'b1;
    tick();

    // Pin the model to hand-computed values.
    chk("model_100", lim_model(100), 160);
    chk("model_255", lim_model(255), 255);
    chk("model_0",   lim_model(0),   0);
`ifdef SQRT_ROUND_EN
    chk("model_2",   lim_model(2),   23);
`else
    chk("model_2",   lim_model(2),   22);
`endif

    run_directed("h100", 8'd100, 8'hA0, 1'b1, 160, 3);
`ifdef SQRT_ROUND_EN
    run_directed("h2", 8'd2, 8'h10, 1'b0, 23, 1);
`else
    run_directed("h2", 8'd2, 8'h10, 1'b0, 22, 1);
`endif
    run_directed("h255", 8'd255, 8'hFF, 1'b0, 255, 2);

    // height 0 with starts pulsed during busy cycles 3 and 9 and during done.
    height = 8'd0; t_act = 8'd0; drop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    first_done = 99; n_done = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      start = (i == 2 || i == 8 || i == 10) ? 1'b1 : 1'b0;
      if (done) begin
        n_done++;
        if (first_done == 99) first_done = i;
      end
    end
    start = 1'b0;
    chk("h0_latency",  first_done, 10);
    chk("h0_n_done",   n_done, 1);
    chk("h0_t_lim",    int'(t_lim), 0);
    chk("h0_status",   int'(status), 3);
    chk("h0_idle",     int'(busy), 0);

    // Reset during S_CALC aborts the computation.
    height = 8'd77; t_act = 8'h20; drop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) n_done++;
    end
    chk("abort_n_done", n_done, 0);
    chk("abort_t_lim",  int'(t_lim), 0);
    chk("abort_status", int'(status), 0);
    chk("abort_busy",   int'(busy), 0);
    run_directed("h50", 8'd50, 8'h70, 1'b1, 113, 1);

    // Random traffic; inputs change every cycle and the model tracks the rest.
    for (int i = 0; i < 1500; i++) begin
      start  = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      height = 8'($urandom);
      if ($urandom_range(0, 2) == 0)
        t_act = 8'(lim_model(int'(height)) + $urandom_range(0, 2) - 1);
      else
        t_act = 8'($urandom);
      drop_en = 1'($urandom);
      rst_n   = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    start = 1'b0; rst_n = 1'b1;
    repeat (15) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
